// File: rtl/rat_alu_mc.sv
// rat_alu_mc: registered RAT ALU with START/BUSY/DONE handshake, registered
// C/Z flags, and an iterative shift-add multiply on opcode 4'hF.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   START, SEL, A, B  operation request, opcode and operands (sampled while idle)
//   CIN               carry in, sampled with START
//   BUSY              high while a multiply is iterating
//   DONE              one-cycle pulse when RESULT/C/Z are updated
//   RESULT, C, Z      registered result and flags
module rat_alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [3:0]       SEL,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             C,
    output logic             Z
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               c_q, c_d;
    logic               z_q, z_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH:0]     alu_w;
    logic               alu_wr;
    logic               alu_keep_c;
    logic [WIDTH:0]     mstep;
    logic [2*WIDTH-1:0] acc_nx;

    // Single-cycle operations, evaluated on WIDTH+1 bits; bit WIDTH is C.
    always_comb begin
        alu_w      = '0;
        alu_wr     = 1'b1;
        alu_keep_c = 1'b0;
        case (SEL)
            4'h0: alu_w = {1'b0, A} + {1'b0, B};
            4'h1: alu_w = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, CIN};
            4'h2: alu_w = {1'b0, A} - {1'b0, B};
            4'h3: alu_w = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, CIN};
            4'h4: begin
                alu_w  = {1'b0, A} - {1'b0, B};
                alu_wr = 1'b0;
            end
            4'h5: alu_w = {1'b0, A & B};
            4'h6: alu_w = {1'b0, A | B};
            4'h7: alu_w = {1'b0, A ^ B};
            4'h8: begin
                alu_w  = {1'b0, A & B};
                alu_wr = 1'b0;
            end
            4'h9: alu_w = {A[WIDTH-1], A[WIDTH-2:0], CIN};
            4'hA: alu_w = {A[0], CIN, A[WIDTH-1:1]};
            4'hB: alu_w = {A[WIDTH-1], A[WIDTH-2:0], A[WIDTH-1]};
            4'hC: alu_w = {A[0], A[0], A[WIDTH-1:1]};
            4'hD: alu_w = {A[0], A[WIDTH-1], A[WIDTH-1:1]};
            4'hE: begin
                alu_w      = {1'b0, B};
                alu_keep_c = 1'b1;
            end
            default: alu_w = '0;
        endcase
    end

    // One shift-add step: upper half accumulates the multiplicand when the
    // current multiplier bit (acc[0]) is set, then the whole pair shifts right.
    always_comb begin
        mstep  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_nx = {mstep, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        c_d      = c_q;
        z_d      = z_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (SEL == 4'hF) begin
                        state_d = S_MUL;
                        mcand_d = A;
                        acc_d   = {{WIDTH{1'b0}}, B};
                        cnt_d   = '0;
                    end else begin
                        done_d = 1'b1;
                        if (alu_wr) result_d = alu_w[WIDTH-1:0];
                        if (!alu_keep_c) c_d = alu_w[WIDTH];
                        z_d = (alu_w[WIDTH-1:0] == '0);
                    end
                end
            end
            S_MUL: begin
                acc_d = acc_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    result_d = acc_nx[WIDTH-1:0];
                    c_d      = |acc_nx[2*WIDTH-1:WIDTH];
                    z_d      = (acc_nx[WIDTH-1:0] == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign BUSY   = (state_q == S_MUL);
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign C      = c_q;
    assign Z      = z_q;

endmodule

// File: tb/tb_rat_alu_mc.sv
// tb_rat_alu_mc: drives an 8-bit and a 16-bit rat_alu_mc in lockstep and
// compares both against an arithmetic reference model.
module tb_rat_alu_mc;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [3:0]  SEL;
    logic [15:0] A16, B16;
    logic        CIN;

    logic        BUSY8, DONE8, C8, Z8;
    logic [7:0]  RES8;
    logic        BUSY16, DONE16, C16, Z16;
    logic [15:0] RES16;

    int tests = 0;
    int fails = 0;

    longint r8, c8, z8, r16, c16, z16;

    always #5 CLK = ~CLK;

    rat_alu_mc #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .START(START), .SEL(SEL),
        .A(A16[7:0]), .B(B16[7:0]), .CIN(CIN),
        .BUSY(BUSY8), .DONE(DONE8), .RESULT(RES8), .C(C8), .Z(Z8)
    );

    rat_alu_mc #(.WIDTH(16)) dut16 (
        .CLK(CLK), .RST(RST), .START(START), .SEL(SEL),
        .A(A16), .B(B16), .CIN(CIN),
        .BUSY(BUSY16), .DONE(DONE16), .RESULT(RES16), .C(C16), .Z(Z16)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result/flags from the opcode table with plain integer math.
    function automatic void model(input int w, input int sel,
                                  input longint a, input longint b,
                                  input longint cin, input longint pr,
                                  input longint pc, output longint nr,
                                  output longint nc, output longint nz);
        longint m, v;
        bit wr;
        m  = (longint'(1) << w) - 1;
        v  = 0;
        wr = 1;
        nr = pr;
        nc = pc;
        case (sel)
            0: begin v = a + b; nc = (v >> w) & 1; end
            1: begin v = a + b + cin; nc = (v >> w) & 1; end
            2: begin v = a - b; nc = (a < b); end
            3: begin v = a - b - cin; nc = (a < b + cin); end
            4: begin v = a - b; nc = (a < b); wr = 0; end
            5: begin v = a & b; nc = 0; end
            6: begin v = a | b; nc = 0; end
            7: begin v = a ^ b; nc = 0; end
            8: begin v = a & b; nc = 0; wr = 0; end
            9: begin v = (a << 1) | cin; nc = (a >> (w - 1)) & 1; end
            10: begin v = (a >> 1) | (cin << (w - 1)); nc = a & 1; end
            11: begin v = (a << 1) | (a >> (w - 1)); nc = (a >> (w - 1)) & 1; end
            12: begin v = (a >> 1) | ((a & 1) << (w - 1)); nc = a & 1; end
            13: begin v = (a >> 1) | (a & (longint'(1) << (w - 1))); nc = a & 1; end
            14: v = b;
            default: begin v = a * b; nc = ((v >> w) != 0); end
        endcase
        if (wr) nr = v & m;
        nz = ((v & m) == 0);
    endfunction

    task automatic run_op(input logic [3:0] sel, input logic [15:0] a,
                          input logic [15:0] b, input logic cin,
                          input int inj);
        longint e8r, e8c, e8z, e16r, e16c, e16z;
        int lat8, lat16, bz8, bz16;
        lat8  = 0;
        lat16 = 0;
        bz8   = 0;
        bz16  = 0;
        model(8, int'(sel), longint'(a[7:0]), longint'(b[7:0]), longint'(cin),
              r8, c8, e8r, e8c, e8z);
        model(16, int'(sel), longint'(a), longint'(b), longint'(cin),
              r16, c16, e16r, e16c, e16z);
        @(negedge CLK);
        START = 1'b1;
        SEL   = sel;
        A16   = a;
        B16   = b;
        CIN   = cin;
        @(posedge CLK);
        #1;
        START = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (lat8 == 0) begin
                if (DONE8) lat8 = cyc;
                else begin
                    if (BUSY8) bz8++;
                    chk("hold8", RES8, 32'(r8));
                end
            end else chk("pulse8", DONE8, 0);
            if (lat16 == 0) begin
                if (DONE16) lat16 = cyc;
                else begin
                    if (BUSY16) bz16++;
                    chk("hold16", RES16, 32'(r16));
                end
            end else chk("pulse16", DONE16, 0);
            if (lat8 != 0 && lat16 != 0) break;
            A16 = 16'($urandom);
            B16 = 16'($urandom);
            CIN = 1'($urandom);
            SEL = 4'($urandom);
            if (cyc == inj) begin
                START = 1'b1;
                SEL   = 4'h0;
            end
            @(posedge CLK);
            #1;
            START = 1'b0;
        end
        chk("lat8", lat8, (sel == 4'hF) ? 9 : 1);
        chk("lat16", lat16, (sel == 4'hF) ? 17 : 1);
        chk("busy8", bz8, (sel == 4'hF) ? 8 : 0);
        chk("busy16", bz16, (sel == 4'hF) ? 16 : 0);
        chk("res8", RES8, 32'(e8r));
        chk("c8", C8, 32'(e8c));
        chk("z8", Z8, 32'(e8z));
        chk("res16", RES16, 32'(e16r));
        chk("c16", C16, 32'(e16c));
        chk("z16", Z16, 32'(e16z));
        @(posedge CLK);
        #1;
        chk("done8_low", DONE8, 0);
        chk("done16_low", DONE16, 0);
        r8  = e8r;
        c8  = e8c;
        z8  = e8z;
        r16 = e16r;
        c16 = e16c;
        z16 = e16z;
    endtask

    initial begin
        longint t8r, t8c, t8z, t16r, t16c, t16z;
        RST   = 1'b1;
        START = 1'b0;
        SEL   = 4'h0;
        A16   = '0;
        B16   = '0;
        CIN   = 1'b0;
        r8 = 0; c8 = 0; z8 = 0; r16 = 0; c16 = 0; z16 = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_res8", RES8, 0);
        chk("rst_flags8", {BUSY8, DONE8, C8, Z8}, 0);
        chk("rst_res16", RES16, 0);
        chk("rst_flags16", {BUSY16, DONE16, C16, Z16}, 0);
        RST = 1'b0;

        run_op(4'h0, 16'h00FF, 16'h0001, 1'b0, 0);
        run_op(4'h3, 16'h0010, 16'h000F, 1'b1, 0);
        run_op(4'h6, 16'h1234, 16'h8001, 1'b0, 0);
        run_op(4'h4, 16'h0005, 16'h0007, 1'b0, 0);
        run_op(4'hF, 16'h0010, 16'h0010, 1'b0, 0);
        run_op(4'hF, 16'h000F, 16'h0003, 1'b0, 0);
        run_op(4'hC, 16'h0001, 16'h0000, 1'b0, 0);
        run_op(4'hF, 16'hFFFF, 16'hFFFF, 1'b0, 0);
        run_op(4'hE, 16'h0000, 16'h0000, 1'b1, 0);
        run_op(4'hD, 16'h8081, 16'h0000, 1'b0, 0);
        run_op(4'hF, 16'h0B37, 16'h00A5, 1'b0, 3);

        // Reset on the fourth MUL cycle, then an immediate new request.
        @(negedge CLK);
        START = 1'b1;
        SEL   = 4'hF;
        A16   = 16'h1234;
        B16   = 16'h00FF;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("busy_mid8", BUSY8, 1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("abort_res8", RES8, 0);
        chk("abort_flags8", {BUSY8, DONE8, C8, Z8}, 0);
        chk("abort_res16", RES16, 0);
        chk("abort_flags16", {BUSY16, DONE16, C16, Z16}, 0);
        RST = 1'b0;
        r8 = 0; c8 = 0; z8 = 0; r16 = 0; c16 = 0; z16 = 0;
        run_op(4'h1, 16'h7F80, 16'h80FF, 1'b1, 0);

        // START held through DONE: second op accepted back to back.
        model(8, 0, 64'h34, 64'h56, 0, r8, c8, t8r, t8c, t8z);
        model(16, 0, 64'h1234, 64'h3456, 0, r16, c16, t16r, t16c, t16z);
        @(negedge CLK);
        START = 1'b1;
        SEL   = 4'h0;
        A16   = 16'h1234;
        B16   = 16'h3456;
        @(posedge CLK);
        #1;
        chk("b2b_done1", {DONE8, DONE16}, 2'b11);
        chk("b2b_res1_8", RES8, 32'(t8r));
        chk("b2b_res1_16", RES16, 32'(t16r));
        model(8, 7, 64'hAA, 64'hAA, 0, t8r, t8c, r8, c8, z8);
        model(16, 7, 64'hAAAA, 64'hAAAA, 0, t16r, t16c, r16, c16, z16);
        SEL = 4'h7;
        A16 = 16'hAAAA;
        B16 = 16'hAAAA;
        @(posedge CLK);
        #1;
        START = 1'b0;
        chk("b2b_done2", {DONE8, DONE16}, 2'b11);
        chk("b2b_res2_8", {RES8, C8, Z8}, 32'({r8[7:0], c8[0], z8[0]}));
        chk("b2b_res2_16", {RES16, C16, Z16}, 32'({r16[15:0], c16[0], z16[0]}));

        repeat (60) begin
            run_op(4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
